// File: rtl/multi_clk_divider_pkg.sv
// Shared types and default constants for the multi-channel clock divider.
package div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 25;
    localparam int DEF_DIV    = 25000000;
    localparam int DEF_MODE   = 0;

endpackage

// File: rtl/multi_clk_divider_channel.sv
// One divider channel: counter, active/pending configuration and registered outputs.
module div_channel
    import div_pkg::*;
#(
    parameter int        CNT_W        = DEF_CNT_W,
    parameter int        DEFAULT_DIV  = DEF_DIV,
    parameter div_mode_e DEFAULT_MODE = MODE_TOGGLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_restart,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic             pend_valid,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] RESET_DIV = (DEFAULT_DIV == 0) ? ONE : CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] div_a_r;
    div_mode_e        mode_a_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pend_v_r;
    logic [CNT_W-1:0] pend_div_r;
    div_mode_e        pend_mode_r;
    logic             clk_out_r;
    logic             tick_r;

    logic             tc_s;
    logic             load_s;
    logic             accept_s;
    logic [CNT_W-1:0] cfg_div_n_s;

    // Terminal-count detect, pending-load condition and zero-divisor normalisation.
    always_comb begin
        tc_s     = (cnt_r == (div_a_r - ONE));
        load_s   = pend_v_r && (!en || sync_restart || tc_s);
        accept_s = cfg_we && !pend_v_r;
        if (cfg_div == '0) begin
            cfg_div_n_s = ONE;
        end else begin
            cfg_div_n_s = cfg_div;
        end
    end

    // Configuration registers: pending slot is filled on accept, promoted only at period boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_a_r     <= RESET_DIV;
            mode_a_r    <= DEFAULT_MODE;
            pend_v_r    <= 1'b0;
            pend_div_r  <= RESET_DIV;
            pend_mode_r <= DEFAULT_MODE;
        end else begin
            if (load_s) begin
                div_a_r  <= pend_div_r;
                mode_a_r <= pend_mode_r;
                pend_v_r <= 1'b0;
            end else if (accept_s) begin
                pend_v_r <= 1'b1;
            end
            if (accept_s) begin
                pend_div_r  <= cfg_div_n_s;
                pend_mode_r <= div_mode_e'(cfg_mode);
            end
        end
    end

    // Counter and outputs; the mode of the period that is ending decides the TC-edge output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= '0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else if (!en || sync_restart) begin
            cnt_r     <= '0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else if (tc_s) begin
            cnt_r     <= '0;
            tick_r    <= 1'b1;
            clk_out_r <= (mode_a_r == MODE_PULSE) ? 1'b1 : ~clk_out_r;
        end else begin
            cnt_r     <= cnt_r + ONE;
            tick_r    <= 1'b0;
            clk_out_r <= (mode_a_r == MODE_PULSE) ? 1'b0 : clk_out_r;
        end
    end

    assign pend_valid = pend_v_r;
    assign clk_out    = clk_out_r;
    assign tick       = tick_r;

endmodule

// File: rtl/multi_clk_divider.sv
// Multi-channel clock divider top: configuration demux, ready mux and restart fan-out.
module multi_clk_divider
    import div_pkg::*;
#(
    parameter  int NUM_CH       = DEF_NUM_CH,
    parameter  int CNT_W        = DEF_CNT_W,
    parameter  int DEFAULT_DIV  = DEF_DIV,
    parameter  int DEFAULT_MODE = DEF_MODE,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam div_mode_e RESET_MODE = (DEFAULT_MODE != 0) ? MODE_PULSE : MODE_TOGGLE;

    logic [NUM_CH-1:0] pend_v_s;
    logic [NUM_CH-1:0] cfg_we_s;
    logic              cfg_ready_s;

    // Out-of-range channel indices read as ready so such requests are consumed and dropped.
    always_comb begin
        cfg_ready_s = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready_s = ~pend_v_s[i];
            end else begin
                cfg_ready_s = cfg_ready_s;
            end
        end
    end

    // Write strobe to the addressed channel only on a completed handshake.
    always_comb begin
        cfg_we_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_valid && cfg_ready_s && (cfg_ch == CH_W'(i))) begin
                cfg_we_s[i] = 1'b1;
            end else begin
                cfg_we_s[i] = 1'b0;
            end
        end
    end

    assign cfg_ready = cfg_ready_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        div_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_MODE (RESET_MODE)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .en           (ch_en[g]),
            .sync_restart (sync_restart),
            .cfg_we       (cfg_we_s[g]),
            .cfg_div      (cfg_div),
            .cfg_mode     (cfg_mode),
            .pend_valid   (pend_v_s[g]),
            .clk_out      (clk_out[g]),
            .tick         (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed plus randomized bench for multi_clk_divider, checked against a tick-scheduling model.
module tb_multi_clk_divider;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DDIV = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] ch_en;
    logic           sync_restart;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_mode;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int total = 0;
    int bad   = 0;

    // Model: each channel's next tick is scheduled as an absolute edge number.
    int ecnt = 0;
    int m_next [NCH];
    int m_div  [NCH];
    bit m_mode [NCH];
    bit m_lvl  [NCH];
    bit m_tick [NCH];
    bit m_pv   [NCH];
    int m_pdiv [NCH];
    bit m_pmode[NCH];

    multi_clk_divider #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .DEFAULT_DIV  (DDIV),
        .DEFAULT_MODE (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_mode     (cfg_mode),
        .clk_out      (clk_out),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]  = DDIV;
            m_mode[i] = 1'b0;
            m_lvl[i]  = 1'b0;
            m_tick[i] = 1'b0;
            m_pv[i]   = 1'b0;
            m_next[i] = ecnt + DDIV;
        end
    endtask

    task automatic reset_edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            ecnt++;
            #1;
            chk("rst_clk_out", 32'(clk_out), 32'd0);
            chk("rst_tick", 32'(tick), 32'd0);
        end
    endtask

    task automatic step();
        bit             fire, exp_rdy, sr, hit, stop;
        bit [NCH-1:0]   en;
        int             ch, d;
        bit             md;
        logic [NCH-1:0] exp_out, exp_tick;
        @(negedge clk);
        ch      = int'(cfg_ch);
        exp_rdy = (ch >= NCH) ? 1'b1 : !m_pv[ch];
        chk("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
        fire = cfg_valid && exp_rdy && (ch < NCH);
        en   = ch_en;
        sr   = sync_restart;
        d    = (cfg_div == '0) ? 1 : int'(cfg_div);
        md   = cfg_mode;
        @(posedge clk);
        ecnt++;
        for (int i = 0; i < NCH; i++) begin
            stop = !en[i] || sr;
            hit  = !stop && (ecnt == m_next[i]);
            m_tick[i] = hit;
            if (stop)         m_lvl[i] = 1'b0;
            else if (hit)     m_lvl[i] = m_mode[i] ? 1'b1 : !m_lvl[i];
            else if (m_mode[i]) m_lvl[i] = 1'b0;
            if (m_pv[i] && (stop || hit)) begin
                m_div[i]  = m_pdiv[i];
                m_mode[i] = m_pmode[i];
                m_pv[i]   = 1'b0;
            end
            if (stop || hit) m_next[i] = ecnt + m_div[i];
            if (fire && ch == i) begin
                m_pv[i]    = 1'b1;
                m_pdiv[i]  = d;
                m_pmode[i] = md;
            end
            exp_out[i]  = m_lvl[i];
            exp_tick[i] = m_tick[i];
        end
        #1;
        chk("clk_out", 32'(clk_out), 32'(exp_out));
        chk("tick", 32'(tick), 32'(exp_tick));
    endtask

    task automatic cfg_step(input int ch, input int div, input bit md);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = CW'(div);
        cfg_mode  = md;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset        = 1'b0;
        ch_en        = '0;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        cfg_ch       = 2'd0;
        cfg_div      = '0;
        cfg_mode     = 1'b0;
        reset_edges(2);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b1;
        model_reset();

        // ch0 div=4 toggle: tick every 4, clk_out period 8
        cfg_step(0, 4, 1'b0);
        ch_en = 3'b001;
        run(20);

        // ch1 div=3 pulse, then div=0 behaves as div=1
        cfg_step(1, 3, 1'b1);
        ch_en = 3'b011;
        run(12);
        cfg_step(1, 0, 1'b1);
        run(10);

        // ch0 div=10, then div=2 requested at cnt=3 of a 10-cycle period
        cfg_step(0, 10, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (m_div[0] == 10 && (m_next[0] - ecnt) == 7) break;
            step();
        end
        chk("cnt3_reached", 32'(m_next[0] - ecnt), 32'd7);
        cfg_step(0, 2, 1'b0);
        run(20);

        // ch0 div=4, ch2 div=6, sync_restart with a same-cycle cfg to ch2
        cfg_step(0, 4, 1'b0);
        cfg_step(2, 6, 1'b0);
        ch_en = 3'b101;
        run(15);
        sync_restart = 1'b1;
        cfg_step(2, 7, 1'b0);
        sync_restart = 1'b0;
        run(20);

        // ch_en[0] drops mid-period with an update pending, then re-enable
        run(2);
        cfg_step(0, 3, 1'b0);
        ch_en = 3'b100;
        run(3);
        ch_en = 3'b101;
        run(10);

        // out-of-range channel is ready and has no effect
        cfg_step(3, 2, 1'b1);
        run(8);

        // async reset mid-period with an update pending
        cfg_step(2, 9, 1'b1);
        run(2);
        @(posedge clk);
        ecnt++;
        #3;
        reset = 1'b0;
        #1;
        chk("async_clk_out", 32'(clk_out), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        cfg_ch = 2'd2;
        #1;
        chk("async_cfg_ready", 32'(cfg_ready), 32'd1);
        reset_edges(2);
        reset = 1'b1;
        model_reset();
        ch_en = 3'b111;
        run(14);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(99, 0) < 5) ch_en[i] = ~ch_en[i];
            end
            sync_restart = ($urandom_range(99, 0) < 3);
            cfg_valid    = ($urandom_range(99, 0) < 30);
            cfg_ch       = 2'($urandom_range(3, 0));
            cfg_div      = CW'($urandom_range(9, 0));
            cfg_mode     = 1'($urandom_range(1, 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
